csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  Machine-mode CSR file for the rv32i core: read/modify/write access (CSRRW/RS/RC), trap entry, mret and interrupt pending.
//  Sits beside the execute stage. The core supplies the CSR address/op and trap/mret events.
//  It returns read data, trap/mret redirect targets and irq_pending. M-mode only; MPP hardwired to 2'b11.
// PARAMETERS
//  HART_ID      0             value of mhartid (0xF14)
//  VENDOR_ID    0             value of mvendorid (0xF11); marchid/mimpid read 0
//  MISA_VALUE   32'h4000_0100 misa (0x301), read-only (RV32I)
//  MTVEC_RESET  32'h0         mtvec reset value
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   asynchronous active-low reset
//  csr_addr     in   12  CSR address
//  csr_op       in   2   01=RW 10=RS 11=RC 00=none
//  csr_we       in   1   write intent (execute has already cleared it for rs1/uimm==0 on RS/RC)
//  csr_wdata    in   32  operand (rs1 or zimm)
//  csr_rdata    out  32  current (pre-write) value of csr_addr, combinational
//  csr_illegal  out  1   unknown addr, or csr_we=1 to read-only addr (addr[11:10]==2'b11)
//  trap_valid   in   1   take trap this cycle
//  trap_cause   in   32  mcause value; bit31=interrupt
//  trap_pc      in   32  faulting/interrupted pc
//  trap_val     in   32  mtval value
//  trap_target  out  32  handler pc, combinational from mtvec and trap_cause
//  mret         in   1   execute mret this cycle
//  mret_target  out  32  = mepc
//  retire       in   1   one instruction retired this cycle
//  irq_ext/irq_timer/irq_sw  in  1 each  level interrupt sources
//  irq_pending  out  1   mstatus.MIE & |(mip & mie)
// BEHAVIOUR
//  Reset: mstatus=0x0000_1800 (MIE=MPIE=0), mie=0, mtvec=MTVEC_RESET, mscratch/mepc/mcause/mtval=0, mip=0.
//   Counters reset to 0. irq_pending=0.
//  Write value: RW->wdata, RS->old|wdata, RC->old&~wdata. Applied at next posedge if csr_we & op!=0 & !csr_illegal.
//  Illegal access: no state change. csr_rdata=0 for unknown addr.
//  Field rules (WARL):
//   mstatus: only MIE[3] and MPIE[7] are writable; [12:11]=11; others 0.
//   mie: only bits 11/7/3 writable. mip: read-only {MEIP[11],MTIP[7],MSIP[3]} = inputs registered 1 cycle.
//   mtvec: write with mode[1:0] in {2,3} keeps the old mode; base is written.
//   mepc: [1:0] forced 0 on any update.
//  trap_target: mode 0 -> {base,2'b00}; mode 1 & cause[31] -> base + 4*cause[4:0]; mode 1 sync -> base.
//  Trap (trap_valid): next edge MPIE<=MIE, MIE<=0, mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_val.
//  mret: next edge MIE<=MPIE, MPIE<=1.
//  Simultaneous events, priority per register: trap > mret > CSR write. The losing writes are dropped.
//  irq_pending is combinational from registered state (1-cycle latency from irq_* pins).
// CONFIGURATION
//  CSR_COUNTERS_EN defined: 64-bit mcycle and minstret.
//   Addresses: mcycle 0xB00/0xB80 (lo/hi), minstret 0xB02/0xB82; read-only shadows 0xC00/0xC80/0xC02/0xC82.
//   mcycle increments every cycle; minstret increments when retire=1; carry propagates lo->hi.
//   A CSR write to a half replaces that half's value for that cycle; no increment is applied to the written half.
//  CSR_COUNTERS_EN undefined: no counter flops; all eight addresses are unknown (rdata=0, csr_illegal=1).
// TESTING
//  Reset, then read 0x300/0x305/0x342 -> 0x0000_1800 / MTVEC_RESET / 0.
//  CSRRS 0x304, wdata 0xFFFF_FFFF -> next read of mie = 0x0000_0888. CSRRW 0xF14 -> csr_illegal=1, mhartid unchanged.
//  mtvec=0x0000_1001, MIE=1, trap cause 0x8000_0007, pc 0x104 -> trap_target=0x101C.
//   Next cycle: mepc=0x104, mstatus=0x1880.
//  Then mret -> mret_target=0x104; next cycle mstatus=0x1888.
//  Same cycle: trap_valid=1 and CSRRW mscratch... plus CSRRW mepc=0x500 -> mepc=trap_pc (trap wins).
//  With CSR_COUNTERS_EN: write mcycle=0xFFFF_FFFF -> 1 cycle later mcycle=0, mcycleh=+1.
//   retire held 5 cycles -> minstret +5.

Source files
------------

// File: rtl/csr_if.sv
// Execute-stage <-> machine-mode CSR file bus: CSR access, trap/mret events,
// interrupt sources and the redirect/pending results.
interface csr_if;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic [31:0] trap_target;
  logic        mret;
  logic [31:0] mret_target;
  logic        retire;
  logic        irq_ext;
  logic        irq_timer;
  logic        irq_sw;
  logic        irq_pending;

  modport master (
    output csr_addr, csr_op, csr_we, csr_wdata,
    output trap_valid, trap_cause, trap_pc, trap_val, mret, retire,
    output irq_ext, irq_timer, irq_sw,
    input  csr_rdata, csr_illegal, trap_target, mret_target, irq_pending
  );

  modport slave (
    input  csr_addr, csr_op, csr_we, csr_wdata,
    input  trap_valid, trap_cause, trap_pc, trap_val, mret, retire,
    input  irq_ext, irq_timer, irq_sw,
    output csr_rdata, csr_illegal, trap_target, mret_target, irq_pending
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file (rv32i): CSRRW/RS/RC, trap entry, mret, irq pending.
// Define CSR_COUNTERS_EN to add 64-bit mcycle/minstret and their shadows.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] VENDOR_ID   = 32'h0,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic clk,
  input  logic rst_n,
  csr_if.slave bus
);
  localparam logic [1:0] OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;

  // mstatus holds only MIE/MPIE; interrupt bits are kept as {ext,timer,sw}
  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [2:0]  mie_q, mie_d, mip_q;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;

  logic [31:0] rdata, wval;
  logic        known, illegal, wr_en;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`else
  logic        unused_retire;
  assign unused_retire = bus.retire;
`endif

  // Read mux: pre-write value, zero for unknown addresses
  always_comb begin
    rdata = 32'h0;
    known = 1'b1;
    case (bus.csr_addr)
      12'h300: rdata = {19'h0, 2'b11, 3'h0, mst_mpie_q, 3'h0, mst_mie_q, 3'h0};
      12'h301: rdata = MISA_VALUE;
      12'h304: rdata = {20'h0, mie_q[2], 3'h0, mie_q[1], 3'h0, mie_q[0], 3'h0};
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'h344: rdata = {20'h0, mip_q[2], 3'h0, mip_q[1], 3'h0, mip_q[0], 3'h0};
      12'hF11: rdata = VENDOR_ID;
      12'hF12: rdata = 32'h0;
      12'hF13: rdata = 32'h0;
      12'hF14: rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: rdata = mcycle_q[31:0];
      12'hB80, 12'hC80: rdata = mcycle_q[63:32];
      12'hB02, 12'hC02: rdata = minstret_q[31:0];
      12'hB82, 12'hC82: rdata = minstret_q[63:32];
`endif
      default: known = 1'b0;
    endcase
  end

  assign illegal = !known || (bus.csr_we && bus.csr_addr[11:10] == 2'b11);
  assign wr_en   = bus.csr_we && (bus.csr_op != 2'b00) && !illegal;

  always_comb begin
    case (bus.csr_op)
      OP_RW:   wval = bus.csr_wdata;
      OP_RS:   wval = rdata | bus.csr_wdata;
      OP_RC:   wval = rdata & ~bus.csr_wdata;
      default: wval = rdata;
    endcase
  end

  // Later assignments win: CSR write < mret < trap
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (wr_en) begin
      case (bus.csr_addr)
        12'h300: begin mst_mie_d = wval[3]; mst_mpie_d = wval[7]; end
        12'h304: mie_d = {wval[11], wval[7], wval[3]};
        12'h305: mtvec_d = wval[1] ? {wval[31:2], mtvec_q[1:0]} : wval;
        12'h340: mscratch_d = wval;
        12'h341: mepc_d = {wval[31:2], 2'b00};
        12'h342: mcause_d = wval;
        12'h343: mtval_d = wval;
        default: ;
      endcase
    end
    if (bus.mret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end
    if (bus.trap_valid) begin
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
      mepc_d     = {bus.trap_pc[31:2], 2'b00};
      mcause_d   = bus.trap_cause;
      mtval_d    = bus.trap_val;
    end
  end

`ifdef CSR_COUNTERS_EN
  // A written half takes the write value and skips its increment this cycle
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'h0, bus.retire};
    if (wr_en) begin
      case (bus.csr_addr)
        12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
        12'hB80: mcycle_d   = {wval, mcycle_q[31:0] + 32'd1};
        12'hB02: minstret_d = {minstret_q[63:32], wval};
        12'hB82: minstret_d = {wval, minstret_q[31:0] + {31'h0, bus.retire}};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= 3'h0;
      mip_q      <= 3'h0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mip_q      <= {bus.irq_ext, bus.irq_timer, bus.irq_sw};
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  // Vectored mode only for interrupts; mode values 2/3 never get stored by writes
  always_comb begin
    if (mtvec_q[1:0] == 2'b01 && bus.trap_cause[31])
      bus.trap_target = {mtvec_q[31:2], 2'b00} + {25'h0, bus.trap_cause[4:0], 2'b00};
    else
      bus.trap_target = {mtvec_q[31:2], 2'b00};
  end

  assign bus.csr_rdata   = rdata;
  assign bus.csr_illegal = illegal;
  assign bus.mret_target = mepc_q;
  assign bus.irq_pending = mst_mie_q && |(mip_q & mie_q);
endmodule

// File: tb/tb_csr_file.sv
// Directed-vector bench for csr_file with hand-computed expectations.
module tb_csr_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  csr_if bus();

  csr_file #(
    .HART_ID(32'h0), .VENDOR_ID(32'h0),
    .MISA_VALUE(32'h4000_0100), .MTVEC_RESET(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.csr_addr = 12'h0; bus.csr_op = 2'b00; bus.csr_we = 1'b0; bus.csr_wdata = 32'h0;
    bus.trap_valid = 1'b0; bus.trap_cause = 32'h0; bus.trap_pc = 32'h0; bus.trap_val = 32'h0;
    bus.mret = 1'b0; bus.retire = 1'b0;
  endtask

  task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    bus.csr_addr = a; bus.csr_op = op; bus.csr_we = 1'b1; bus.csr_wdata = d;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_addr = a; bus.csr_op = 2'b00; bus.csr_we = 1'b0;
    #1;
    check(tag, bus.csr_rdata, exp);
  endtask

  initial begin
    idle();
    bus.irq_ext = 1'b0; bus.irq_timer = 1'b0; bus.irq_sw = 1'b0;
    #2;
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    check("rst_irq_pending", {31'h0, bus.irq_pending}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd("mstatus", 12'h300, 32'h0000_1800);
    rd("mtvec", 12'h305, 32'h0);
    rd("mcause", 12'h342, 32'h0);
    rd("misa", 12'h301, 32'h4000_0100);
    tick();

    // CSRRS mie with all ones: only 11/7/3 stick
    drive(12'h304, 2'b10, 32'hFFFF_FFFF); #1;
    check("mie_rs_prewrite", bus.csr_rdata, 32'h0);
    check("mie_rs_legal", {31'h0, bus.csr_illegal}, 32'h0);
    tick(); idle();
    rd("mie_after_rs", 12'h304, 32'h0000_0888);

    // write to read-only mhartid
    drive(12'hF14, 2'b01, 32'h5); #1;
    check("mhartid_wr_illegal", {31'h0, bus.csr_illegal}, 32'h1);
    tick(); idle();
    rd("mhartid_unchanged", 12'hF14, 32'h0);
    check("mhartid_rd_legal", {31'h0, bus.csr_illegal}, 32'h0);
    rd("unknown_rdata", 12'h7C0, 32'h0);
    check("unknown_illegal", {31'h0, bus.csr_illegal}, 32'h1);
    tick();

    drive(12'h305, 2'b01, 32'h0000_1001); tick(); idle();
    rd("mtvec_vec", 12'h305, 32'h0000_1001);
    tick();
    drive(12'h300, 2'b10, 32'h0000_0008); tick(); idle();
    rd("mstatus_mie", 12'h300, 32'h0000_1808);
    tick();

    // timer interrupt: one cycle of register latency
    bus.irq_timer = 1'b1; #1;
    check("irq_pending_lat", {31'h0, bus.irq_pending}, 32'h0);
    tick();
    check("irq_pending_set", {31'h0, bus.irq_pending}, 32'h1);
    rd("mip_timer", 12'h344, 32'h0000_0080);
    bus.irq_timer = 1'b0;
    tick();

    // vectored interrupt trap
    bus.trap_valid = 1'b1; bus.trap_cause = 32'h8000_0007;
    bus.trap_pc = 32'h104; bus.trap_val = 32'h55; #1;
    check("trap_target_vec", bus.trap_target, 32'h0000_101C);
    tick(); idle();
    rd("trap_mepc", 12'h341, 32'h104);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    rd("trap_mcause", 12'h342, 32'h8000_0007);
    rd("trap_mtval", 12'h343, 32'h55);
    check("irq_pending_masked", {31'h0, bus.irq_pending}, 32'h0);
    tick();

    bus.mret = 1'b1; #1;
    check("mret_target", bus.mret_target, 32'h104);
    tick(); idle();
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    tick();

    // sync trap racing a CSRRW to mepc: trap wins
    drive(12'h341, 2'b01, 32'h500);
    bus.trap_valid = 1'b1; bus.trap_cause = 32'h2; bus.trap_pc = 32'h207; #1;
    check("trap_target_sync", bus.trap_target, 32'h0000_1000);
    tick(); idle();
    rd("race_mepc", 12'h341, 32'h204);
    rd("race_mstatus", 12'h300, 32'h0000_1880);
    tick();

    drive(12'h341, 2'b01, 32'h503); tick(); idle();
    rd("mepc_align", 12'h341, 32'h500);
    tick();

    // mret racing a CSRRC of MPIE: mret wins
    drive(12'h300, 2'b11, 32'h80); bus.mret = 1'b1;
    tick(); idle();
    rd("mret_vs_write", 12'h300, 32'h0000_1888);
    tick();
    drive(12'h300, 2'b01, 32'hFFFF_FF77); tick(); idle();
    rd("mstatus_warl", 12'h300, 32'h0000_1800);
    tick();

    drive(12'h305, 2'b01, 32'h0000_2002); tick(); idle();
    rd("mtvec_mode_keep", 12'h305, 32'h0000_2001);
    tick();
    drive(12'h305, 2'b01, 32'h0000_3000); tick(); idle();
    bus.trap_cause = 32'h8000_0003; #1;
    check("trap_target_direct", bus.trap_target, 32'h0000_3000);
    idle();
    tick();

    drive(12'h340, 2'b01, 32'hDEAD_BEEF); tick();
    drive(12'h340, 2'b10, 32'h0000_0010); #1;
    check("mscratch_rs_prewrite", bus.csr_rdata, 32'hDEAD_BEEF);
    tick();
    drive(12'h340, 2'b11, 32'h0000_000F); tick(); idle();
    rd("mscratch_rc", 12'h340, 32'hDEAD_BEF0);
    tick();

`ifdef CSR_COUNTERS_EN
    drive(12'hB00, 2'b01, 32'hFFFF_FFFF); tick(); idle();
    rd("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd("mcycle_wrap", 12'hB00, 32'h0);
    rd("mcycleh_carry", 12'hB80, 32'h1);
    rd("minstret_base", 12'hB02, 32'h0);
    bus.retire = 1'b1;
    repeat (5) tick();
    bus.retire = 1'b0;
    rd("minstret_5", 12'hB02, 32'h5);
    rd("minstret_shadow", 12'hC02, 32'h5);
`else
    rd("no_mcycle_rdata", 12'hB00, 32'h0);
    check("no_mcycle_illegal", {31'h0, bus.csr_illegal}, 32'h1);
    rd("no_minstreth_shadow", 12'hC82, 32'h0);
    check("no_shadow_illegal", {31'h0, bus.csr_illegal}, 32'h1);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
